// File: rtl/alu_muldiv.sv
// Single-cycle ALU with an iterative shift-add MULTU and, when ALU_MULDIV_DIV_EN is
// defined, a restoring DIVU that produce HI/LO one bit per cycle.
module alu_muldiv #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;
    logic                 done;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     alu_c;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   step_next;

    // Single-cycle result
    always_comb begin
        alu_c = '0;
        case (ctrl)
            4'b0000: alu_c = x + y;
            4'b0001: alu_c = x - y;
            4'b0010: alu_c = x & y;
            4'b0011: alu_c = x | y;
            4'b0100: alu_c = x ^ y;
            4'b0101: alu_c = ~(x | y);
            4'b0110: alu_c = WIDTH'(x < y);
            4'b0111: alu_c = WIDTH'($signed(x) < $signed(y));
            4'b1000: alu_c = y << shamt;
            4'b1001: alu_c = y >> shamt;
            4'b1011: alu_c = WIDTH'($signed(y) >>> shamt);
            4'b1110: alu_c = hi;
            4'b1111: alu_c = lo;
            default: alu_c = '0;
        endcase
    end

    // Shift-add step: upper half accumulates the multiplicand, then {acc,mplier} shifts right
    always_comb begin
        mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? b : {WIDTH{1'b0}})};
        mul_next = {mul_sum, p[WIDTH-1:1]};
    end

`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    // Restoring step: p holds {remainder, dividend bits still to be consumed / quotient}
    always_comb begin
        div_shift = p[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b};
        step_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  p[WIDTH-2:0], 1'b1};
        if (state != DIV) begin
            step_next = mul_next;
        end
    end
`else
    always_comb begin
        step_next = mul_next;
    end
`endif

    always_comb begin
        cnt_inc = cnt + CW'(1);
        done    = (cnt_inc == CW'(WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            p         <= '0;
            b         <= '0;
            out       <= '0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (ctrl == 4'b1100) begin
                            state    <= MUL;
                            in_ready <= 1'b0;
                            cnt      <= '0;
                            p        <= {{WIDTH{1'b0}}, y};
                            b        <= x;
`ifdef ALU_MULDIV_DIV_EN
                        end else if (ctrl == 4'b1101) begin
                            state    <= DIV;
                            in_ready <= 1'b0;
                            cnt      <= '0;
                            p        <= {{WIDTH{1'b0}}, x};
                            b        <= y;
`endif
                        end else begin
                            out       <= alu_c;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    p   <= step_next;
                    cnt <= cnt_inc;
                    if (done) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        hi        <= step_next[2*WIDTH-1:WIDTH];
                        lo        <= step_next[WIDTH-1:0];
                        out       <= step_next[WIDTH-1:0];
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32); follows ALU_MULDIV_DIV_EN for 1101 expectations.
module tb_alu_muldiv;

`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] x, y;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] out, hi, lo;

    typedef struct {
        logic [31:0] o;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .x(x), .y(y), .shamt(shamt),
        .out_valid(out_valid), .out(out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out=%h with no pending op", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_out", out, e.o);
                chk("result_hi", hi, e.h);
                chk("result_lo", lo, e.l);
            end
        end
    end

    // Issue one op; waits (bounded) for in_ready, checks accept-cycle handshake
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] bb,
                         input logic [4:0] s, input bit push,
                         input logic [31:0] eo, input logic [31:0] eh, input logic [31:0] el);
        int  n;
        bit  multi;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("ready_before_issue", in_ready, 1'b1);
        multi = (c == 4'b1100) || (DIV_EN && c == 4'b1101);
        ctrl = c; x = a; y = bb; shamt = s; in_valid = 1'b1;
        if (push) begin
            e.o = eo; e.h = eh; e.l = el;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (multi) begin
            chk1("multi_busy_after_accept", in_ready, 1'b0);
        end else begin
            chk1("single_valid_next_cycle", out_valid, 1'b1);
            chk1("single_ready_stays", in_ready, 1'b1);
        end
    endtask

    // Ride out a multicycle op with ignored in_valid pulses; completion due at edge 32
    task automatic finish_multi();
        for (int i = 1; i < 32; i++) begin
            ctrl = 4'b0000; x = $urandom; y = $urandom; in_valid = i[0];
            @(posedge clk); #1;
            chk1("busy_in_ready", in_ready, 1'b0);
            chk1("busy_no_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk1("multi_done_valid", out_valid, 1'b1);
        chk1("multi_done_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; ctrl = '0; x = '0; y = '0; shamt = '0;
        @(posedge clk); #1;
        chk("reset_out", out, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("ready_after_reset", in_ready, 1'b1);

        do_op(4'b0001, 32'd5, 32'd7, 5'd0, 1, 32'hFFFFFFFE, 32'h0, 32'h0);
        do_op(4'b0110, 32'hFFFFFFFF, 32'd1, 5'd0, 1, 32'h0, 32'h0, 32'h0);
        do_op(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 1, 32'h1, 32'h0, 32'h0);
        do_op(4'b0000, 32'hFFFFFFFF, 32'd2, 5'd0, 1, 32'h1, 32'h0, 32'h0);
        do_op(4'b0010, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 32'h00F0F000, 32'h0, 32'h0);
        do_op(4'b0011, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 32'hFFF0FFF0, 32'h0, 32'h0);
        do_op(4'b0100, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 32'hFF000FF0, 32'h0, 32'h0);
        do_op(4'b0101, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 32'h000F000F, 32'h0, 32'h0);
        do_op(4'b1011, 32'h0, 32'h80000000, 5'd4, 1, 32'hF8000000, 32'h0, 32'h0);
        do_op(4'b1001, 32'h0, 32'h80000000, 5'd4, 1, 32'h08000000, 32'h0, 32'h0);
        do_op(4'b1011, 32'h0, 32'h80000000, 5'd0, 1, 32'h80000000, 32'h0, 32'h0);
        do_op(4'b1000, 32'h0, 32'h00000001, 5'd31, 1, 32'h80000000, 32'h0, 32'h0);
        do_op(4'b1010, 32'h12345678, 32'h9ABCDEF0, 5'd3, 1, 32'h0, 32'h0, 32'h0);

        do_op(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1, 32'h1, 32'hFFFFFFFE, 32'h1);
        finish_multi();
        do_op(4'b1110, 32'h0, 32'h0, 5'd0, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h1);
        do_op(4'b1111, 32'h0, 32'h0, 5'd0, 1, 32'h1, 32'hFFFFFFFE, 32'h1);

        if (DIV_EN) begin
            do_op(4'b1101, 32'd100, 32'd7, 5'd0, 1, 32'd14, 32'd2, 32'd14);
            finish_multi();
            do_op(4'b1101, 32'd100, 32'd0, 5'd0, 1, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF);
            finish_multi();
        end else begin
            do_op(4'b1101, 32'd100, 32'd7, 5'd0, 1, 32'h0, 32'hFFFFFFFE, 32'h1);
        end

        do_op(4'b1100, 32'h12345678, 32'h00000010, 5'd0, 1, 32'h23456780, 32'h1, 32'h23456780);
        finish_multi();

        // Abort a MULTU at cycle 10; it must never report a result
        do_op(4'b1100, 32'd3, 32'd5, 5'd0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk1("mid_mul_busy", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_out", out, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("ready_after_abort", in_ready, 1'b1);
        chk1("no_valid_after_abort", out_valid, 1'b0);
        do_op(4'b0000, 32'd2, 32'd3, 5'd0, 1, 32'd5, 32'h0, 32'h0);
        do_op(4'b1110, 32'h0, 32'h0, 5'd0, 1, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
        end
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
